// File: rtl/pipearch_read_if.sv
// CCI-P channel-0 types (read-path subset) and the pipearch_read port bundle.
// The operator side is the master; the reader block is the slave.
package pipearch_read_pkg;
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
    typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;
endpackage

interface pipearch_read_if;
    import pipearch_read_pkg::*;

    logic             op_start;
    logic             op_done;
    logic [4:0][31:0] regs;
    t_ccip_clAddr     in_addr;
    t_ccip_clAddr     out_addr;
    logic             out_rvalid;
    logic [511:0]     out_rdata;
    logic             out_almostfull;
    logic             c0TxAlmFull;
    t_if_ccip_c0_Rx   cp2af_sRx_c0;
    t_if_ccip_c0_Tx   af2cp_sTx_c0;

    modport master (
        output op_start, regs, in_addr, out_addr, out_almostfull, c0TxAlmFull, cp2af_sRx_c0,
        input  op_done, out_rvalid, out_rdata, af2cp_sTx_c0
    );
    modport slave (
        input  op_start, regs, in_addr, out_addr, out_almostfull, c0TxAlmFull, cp2af_sRx_c0,
        output op_done, out_rvalid, out_rdata, af2cp_sTx_c0
    );
endinterface

// File: rtl/pipearch_read.sv
// Cache-line reader: issues CCI-P channel-0 reads for a contiguous run of lines,
// reorders the responses in a ROB indexed by mdata and streams lines in address order.
module pipearch_read #(
    parameter int ROB_DEPTH = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    pipearch_read_if.slave bus
);
    import pipearch_read_pkg::*;

    localparam int AW = $clog2(ROB_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                 state;
    t_ccip_clAddr           base;
    logic [15:0]            len;
    logic [15:0]            issued;
    logic [15:0]            delivered;
    logic [ROB_DEPTH-1:0]   valid;
    logic [511:0]           rob [ROB_DEPTH];
    logic [AW-1:0]          head;
    logic [AW-1:0]          wslot;
    logic                   can_issue;
    logic                   do_deliver;
    logic                   rsp_ok;
    logic                   unused_bits;

    assign head  = delivered[AW-1:0];
    assign wslot = bus.cp2af_sRx_c0.hdr.mdata[AW-1:0];

    // Responses outside READ (idle, or stragglers of an aborted op) are dropped.
    assign rsp_ok     = (state == READ) && bus.cp2af_sRx_c0.rspValid &&
                        (bus.cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);
    assign can_issue  = (state == READ) && (issued < len) && !bus.c0TxAlmFull &&
                        ((issued - delivered) < 16'(ROB_DEPTH));
    // Uses the registered valid bit, so a same-cycle write to the head slot waits a cycle.
    assign do_deliver = (state == READ) && valid[head] && !bus.out_almostfull;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            base             <= '0;
            len              <= '0;
            issued           <= '0;
            delivered        <= '0;
            valid            <= '0;
            bus.op_done      <= 1'b0;
            bus.out_rvalid   <= 1'b0;
            bus.af2cp_sTx_c0 <= '0;
        end else begin
            bus.op_done            <= (state == DONE);
            bus.out_rvalid         <= do_deliver;
            bus.af2cp_sTx_c0.valid <= can_issue;
            if (can_issue) begin
                bus.af2cp_sTx_c0.hdr <= '{vc_sel:   eVC_VA,
                                          rsvd1:    2'b0,
                                          cl_len:   eCL_LEN_1,
                                          req_type: eREQ_RDLINE_I,
                                          rsvd0:    6'b0,
                                          address:  base + t_ccip_clAddr'(issued),
                                          mdata:    t_ccip_mdata'(issued[AW-1:0])};
                issued <= issued + 16'd1;
            end
            if (do_deliver) begin
                valid[head] <= 1'b0;
                delivered   <= delivered + 16'd1;
            end
            if (rsp_ok)
                valid[wslot] <= 1'b1;

            case (state)
                IDLE: if (bus.op_start) begin
                    base      <= (bus.regs[0][31] ? bus.out_addr : bus.in_addr) +
                                 {11'b0, bus.regs[0][30:0]};
                    len       <= bus.regs[1][15:0];
                    issued    <= '0;
                    delivered <= '0;
                    valid     <= '0;
                    state     <= (bus.regs[1][15:0] == 16'd0) ? DONE : READ;
                end
                READ: if (do_deliver && (delivered + 16'd1 == len))
                    state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; valid bits alone say what is live.
    always_ff @(posedge clk) begin
        if (rsp_ok)
            rob[wslot] <= bus.cp2af_sRx_c0.data;
        if (do_deliver)
            bus.out_rdata <= rob[head];
    end

    assign unused_bits = ^{bus.regs[4:2], bus.regs[1][31:16], bus.cp2af_sRx_c0};
endmodule

// File: tb/tb_pipearch_read.sv
// Randomized bench for pipearch_read: a responder with several return orders and
// a line-level model that checks every request, every delivered beat and op_done.
module tb_pipearch_read;
  import pipearch_read_pkg::*;

  localparam int D = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pipearch_read_if bus();

  pipearch_read #(.ROB_DEPTH(D)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input t_ccip_clAddr a);
    logic [31:0] w;
    w = (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {16{w}};
  endfunction

  // Line-level model: expected base/length and how many lines were requested/delivered.
  int           cyc = 0;
  bit           active = 0;
  t_ccip_clAddr m_base = '0;
  int           m_len = 0;
  int           req_cnt = 0;
  int           del_cnt = 0;
  int           done_due = -1;
  int           done_cyc = -1;
  int           beats_total = 0;
  int           start_cyc = 0;
  int           first_req_cyc = -1;
  t_ccip_clAddr first_addr = '0;
  t_ccip_clAddr last_addr = '0;
  int           rsp_cyc[int];
  bit           c0a_e = 0;
  bit           oaf_e = 0;

  always begin
    @(posedge clk);
    cyc++;
    c0a_e = bus.c0TxAlmFull;
    oaf_e = bus.out_almostfull;
    @(negedge clk);
    if (reset_n) begin
      if (bus.af2cp_sTx_c0.valid) begin
        chk("req_active", active && (req_cnt < m_len), 1);
        chk("req_almfull", c0a_e, 0);
        chk("req_addr", bus.af2cp_sTx_c0.hdr.address, m_base + t_ccip_clAddr'(req_cnt));
        chk("req_mdata", bus.af2cp_sTx_c0.hdr.mdata, req_cnt % D);
        chk("req_hdr", {bus.af2cp_sTx_c0.hdr.vc_sel, bus.af2cp_sTx_c0.hdr.cl_len, bus.af2cp_sTx_c0.hdr.req_type},
            {eVC_VA, eCL_LEN_1, eREQ_RDLINE_I});
        chk("req_window", (req_cnt - del_cnt) < D, 1);
        if (req_cnt == 0) begin
          first_req_cyc = cyc;
          first_addr = bus.af2cp_sTx_c0.hdr.address;
        end
        last_addr = bus.af2cp_sTx_c0.hdr.address;
        req_cnt++;
      end
      if (bus.out_rvalid) begin
        chk("dlv_active", active && (del_cnt < m_len), 1);
        chk("dlv_afull", oaf_e, 0);
        chk("dlv_data", bus.out_rdata, line_data(m_base + t_ccip_clAddr'(del_cnt)));
        chk("dlv_latency", rsp_cyc.exists(del_cnt) && (cyc >= rsp_cyc[del_cnt] + 2), 1);
        del_cnt++;
        beats_total++;
        if (active && del_cnt == m_len) done_due = cyc + 1;
      end
      chk("op_done", bus.op_done, active && (cyc == done_due));
      if (bus.op_done) begin
        done_cyc = cyc;
        active = 0;
      end
    end
  end

  // Responder: 0 = in order after 10 cycles, 1 = groups of 4 reversed, 2 = random order.
  typedef struct { t_ccip_mdata md; t_ccip_clAddr a; int rdy; } pend_t;
  pend_t pool[$];
  int    rmode = 0;
  bit    hold = 0;
  bit    noise = 0;
  int    grp = 0;

  initial begin
    bus.cp2af_sRx_c0 = '0;
    forever begin
      int idx;
      int ready[$];
      logic [31:0] w;
      @(negedge clk);
      bus.cp2af_sRx_c0.rspValid = 1'b0;
      bus.cp2af_sRx_c0.mmioRdValid = 1'b0;
      if (reset_n && bus.af2cp_sTx_c0.valid)
        pool.push_back('{md: bus.af2cp_sTx_c0.hdr.mdata, a: bus.af2cp_sTx_c0.hdr.address,
                         rdy: cyc + ((rmode == 0) ? 10 : int'($urandom_range(1, 20)))});
      idx = -1;
      if (!hold && pool.size() > 0) begin
        case (rmode)
          0: if (pool[0].rdy <= cyc) idx = 0;
          1: begin
            if (grp == 0 && (pool.size() >= 4 || req_cnt == m_len))
              grp = (pool.size() >= 4) ? 4 : pool.size();
            if (grp > 0) begin
              idx = grp - 1;
              grp--;
            end
          end
          default: begin
            ready.delete();
            foreach (pool[i]) if (pool[i].rdy <= cyc) ready.push_back(i);
            if (ready.size() > 0 && $urandom_range(0, 3) != 0)
              idx = ready[$urandom_range(0, ready.size() - 1)];
          end
        endcase
      end
      if (idx >= 0) begin
        bus.cp2af_sRx_c0.rspValid = 1'b1;
        bus.cp2af_sRx_c0.hdr.resp_type = eRSP_RDLINE;
        bus.cp2af_sRx_c0.hdr.mdata = pool[idx].md;
        bus.cp2af_sRx_c0.data = line_data(pool[idx].a);
        if (active) rsp_cyc[int'(pool[idx].a - m_base)] = cyc;
        pool.delete(idx);
      end else if (noise && $urandom_range(0, 2) == 0) begin
        w = $urandom;
        bus.cp2af_sRx_c0.rspValid = 1'b1;
        bus.cp2af_sRx_c0.hdr.resp_type = eRSP_UMSG;
        bus.cp2af_sRx_c0.hdr.mdata = t_ccip_mdata'($urandom);
        bus.cp2af_sRx_c0.data = {16{w}};
      end else if (noise) begin
        bus.cp2af_sRx_c0.mmioRdValid = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic start_op(input logic [31:0] r0, input logic [31:0] r1, input bit taken);
    @(negedge clk);
    bus.regs = '0;
    bus.regs[0] = r0;
    bus.regs[1] = r1;
    bus.op_start = 1'b1;
    if (taken) begin
      m_base = (r0[31] ? bus.out_addr : bus.in_addr) + t_ccip_clAddr'(r0[30:0]);
      m_len = int'(r1[15:0]);
      req_cnt = 0;
      del_cnt = 0;
      first_req_cyc = -1;
      rsp_cyc.delete();
      grp = 0;
      start_cyc = cyc;
      done_due = (m_len == 0) ? cyc + 2 : -1;
      active = 1;
    end
    @(negedge clk);
    bus.op_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (active && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, active, 0);
  endtask

  initial begin
    int b0;
    int n;
    bus.op_start = 1'b0;
    bus.regs = '0;
    bus.in_addr = 42'h1000;
    bus.out_addr = 42'h3_0000_1000;
    bus.out_almostfull = 1'b0;
    bus.c0TxAlmFull = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", bus.out_rvalid, 0);
    chk("rst_txvalid", bus.af2cp_sTx_c0.valid, 0);
    chk("rst_done", bus.op_done, 0);
    reset_n = 1'b1;

    // In order, 8 lines from in_addr + 4
    rmode = 0;
    b0 = beats_total;
    start_op(32'd4, 32'd8, 1);
    wait_idle(300, "t1_timeout");
    chk("t1_first_req_lat", first_req_cyc - start_cyc, 2);
    chk("t1_first_addr", first_addr, 42'h1004);
    chk("t1_last_addr", last_addr, 42'h100B);
    chk("t1_beats", beats_total - b0, 8);

    // Reversed groups of 4, 16 lines
    rmode = 1;
    @(negedge clk);
    bus.in_addr = t_ccip_clAddr'($urandom);
    b0 = beats_total;
    start_op(32'($urandom_range(0, 1000)), 32'd16, 1);
    wait_idle(500, "t2_timeout");
    chk("t2_beats", beats_total - b0, 16);

    // Random order with noise, both backpressures, and an ignored second start
    rmode = 2;
    noise = 1;
    b0 = beats_total;
    start_op(32'($urandom_range(0, 5000)), 32'd100, 1);
    repeat (5) @(negedge clk);
    bus.c0TxAlmFull = 1'b1;
    repeat (20) @(negedge clk);
    bus.c0TxAlmFull = 1'b0;
    start_op(32'h0000_0777, 32'd3, 0);
    bus.out_almostfull = 1'b1;
    repeat (30) @(negedge clk);
    bus.out_almostfull = 1'b0;
    n = 0;
    while (active && n < 3000) begin
      @(negedge clk);
      bus.out_almostfull = ($urandom_range(0, 3) == 0);
      bus.c0TxAlmFull = ($urandom_range(0, 4) == 0);
      n++;
    end
    bus.out_almostfull = 1'b0;
    bus.c0TxAlmFull = 1'b0;
    wait_idle(500, "t3_timeout");
    chk("t3_beats", beats_total - b0, 100);
    noise = 0;

    // Window limit: responses held, 200 lines
    rmode = 0;
    hold = 1;
    b0 = beats_total;
    start_op(32'($urandom_range(0, 100)), 32'd200, 1);
    repeat (150) @(negedge clk);
    chk("win_issued", req_cnt, 64);
    chk("win_delivered", del_cnt, 0);
    hold = 0;
    wait_idle(3000, "t4_timeout");
    chk("t4_beats", beats_total - b0, 200);

    // Zero length
    b0 = beats_total;
    start_op(32'd0, 32'd0, 1);
    wait_idle(20, "zl_timeout");
    chk("zl_done_lat", done_cyc - start_cyc, 2);
    chk("zl_reqs", req_cnt, 0);
    chk("zl_beats", beats_total - b0, 0);

    // out_addr base select
    rmode = 2;
    start_op(32'h8000_0002, 32'd5, 1);
    wait_idle(500, "t6_timeout");
    chk("t6_first_addr", first_addr, 42'h3_0000_1002);

    // Reset mid-transfer, stale responses, then a fresh op
    start_op(32'd0, 32'd120, 1);
    repeat (40) @(negedge clk);
    #2;
    reset_n = 1'b0;
    active = 0;
    done_due = -1;
    #1;
    chk("mid_rst_rvalid", bus.out_rvalid, 0);
    chk("mid_rst_txvalid", bus.af2cp_sTx_c0.valid, 0);
    chk("mid_rst_done", bus.op_done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    b0 = beats_total;
    repeat (150) @(negedge clk);
    chk("stale_beats", beats_total - b0, 0);
    pool.delete();
    rmode = 1;
    b0 = beats_total;
    start_op(32'd9, 32'd20, 1);
    wait_idle(500, "t7_timeout");
    chk("t7_beats", beats_total - b0, 20);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
